// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The optional performance counters in instr_fetch_unit are enabled by FETCH_PERF_CNT_EN.
package fetch_pkg;

   localparam int FETCH_ADDR_W = 32;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef enum logic {
      FETCH = 1'b0,
      FLUSH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0]             inst;
      logic [FETCH_ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs until decode takes them.
// A flush empties it in one cycle; flush wins over a push in the same cycle.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   output fetch_entry_t     head_entry,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_W'(DEPTH));
   assign count      = count_q;
   assign head_entry = mem_q[rd_ptr_q];

   // Next-state for storage and pointers; a pop frees the slot a simultaneous push may reuse.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = next_ptr(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Register the FIFO state; reset leaves it empty with cleared storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: owns the PC, issues word reads to imem, buffers the returned
// instructions and throws away wrong-path responses after a redirect.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_flushed counter outputs.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 2
)
(
   input  logic              clk,
   input  logic              reset_n,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_flushed
`endif
);

   localparam int                CNT_W      = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0]    DEPTH_L    = (CNT_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   fetch_state_e      state_q, state_d;
   logic              req_valid_q, req_valid_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

   logic              req_fire, rsp_accept, rsp_drop, rsp_keep, rsp_lost, pop, credit_ok;
   logic [ADDR_W-1:0] target;
   logic [CNT_W-1:0]  buf_count, buf_count_next;
   logic              buf_empty, buf_full;
   fetch_entry_t      push_entry, head_entry;

   assign push_entry = '{inst: imem_rsp_data, pc: FETCH_ADDR_W'(resp_pc_q)};

   fetch_buffer #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_buffer (
      .clk        (clk),
      .rst_n      (reset_n),
      .flush      (redirect_valid),
      .push       (rsp_keep),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .count      (buf_count),
      .empty      (buf_empty),
      .full       (buf_full)
   );

   assign imem_req_valid = req_valid_q;
   assign imem_addr      = pc_q;
   assign inst_valid     = !buf_empty;
   assign inst_data      = inst_valid ? head_entry.inst : NOP_INST;
   assign inst_pc        = inst_valid ? ADDR_W'(head_entry.pc) : RESET_PC;

   // Classify this cycle's events; responses are only honoured while something is in flight.
   always_comb begin
      req_fire       = req_valid_q && imem_req_ready;
      rsp_accept     = imem_rsp_valid && (outstanding_q != '0);
      rsp_drop       = rsp_accept && (drop_cnt_q != '0);
      rsp_keep       = rsp_accept && (drop_cnt_q == '0) && !redirect_valid;
      rsp_lost       = rsp_accept && (drop_cnt_q == '0) && redirect_valid;
      pop            = inst_valid && inst_ready;
      target         = redirect_target & ALIGN_MASK;
      outstanding_d  = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_accept);
      buf_count_next = redirect_valid ? '0 : (buf_count + CNT_W'(rsp_keep) - CNT_W'(pop));
      credit_ok      = ({1'b0, outstanding_d} + {1'b0, buf_count_next}) < DEPTH_L;
   end

   // PC, response PC, drop count and the registered request; a redirect overrides everything.
   always_comb begin
      if (redirect_valid) begin
         pc_d        = target;
         resp_pc_d   = target;
         drop_cnt_d  = outstanding_d;
         req_valid_d = credit_ok;
      end else begin
         pc_d        = req_fire ? (pc_q + STEP) : pc_q;
         resp_pc_d   = rsp_keep ? (resp_pc_q + STEP) : resp_pc_q;
         drop_cnt_d  = drop_cnt_q - CNT_W'(rsp_drop);
         req_valid_d = (req_valid_q && !imem_req_ready) ? 1'b1 : credit_ok;
      end
   end

   // FLUSH lasts exactly as long as stale responses remain to be discarded.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   if (redirect_valid && (drop_cnt_d != '0)) state_d = FLUSH;
         FLUSH:   if (drop_cnt_d == '0) state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // All fetch control state, including the registered imem request outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= FETCH;
         req_valid_q   <= 1'b0;
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         req_valid_q   <= req_valid_d;
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(rsp_keep && buf_full));

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_flushed_q, perf_flushed_d;
   logic [33:0] flushed_sum;

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;

   // Saturating counts of delivered instructions and of discarded wrong-path work.
   always_comb begin
      perf_fetched_d = (pop && !(&perf_fetched_q)) ? perf_fetched_q + 32'd1 : perf_fetched_q;
      flushed_sum    = {2'b00, perf_flushed_q} + 34'(rsp_drop) + 34'(rsp_lost);
      if (redirect_valid) begin
         flushed_sum = flushed_sum + 34'(buf_count) - 34'(pop);
      end
      perf_flushed_d = (flushed_sum[33:32] != 2'b00) ? '1 : flushed_sum[31:0];
   end

   // Counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_flushed_q <= perf_flushed_d;
      end
   end
`endif

endmodule
